// File: rtl/flag_branch_unit.sv
// flag_branch_unit: architectural Z/V/N flag register plus conditional-branch
// resolution, with an in-flight flag-writer counter and EX-to-branch forwarding.
module flag_branch_unit #(
    parameter int unsigned PC_W   = 16,
    parameter int unsigned PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [3:0]        alu_op,
    input  logic [2:0]        alu_flag,
    input  logic              id_fs_issue,
    input  logic              br_valid,
    input  logic [2:0]        br_ccc,
    input  logic [PC_W-1:0]   br_target,
    input  logic [PC_W-1:0]   pc_next,
    output logic              br_ready,
    output logic              br_resolved,
    output logic              br_taken,
    output logic [PC_W-1:0]   next_pc,
    output logic [2:0]        flags_q,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              err
);

    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [PEND_W-1:0] PEND_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESOLVE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        flags_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              resolved_q, resolved_d;
    logic              taken_q, taken_d;
    logic [PC_W-1:0]   npc_q, npc_d;
    logic              err_q, err_d;

    logic [2:0]        wr_mask;
    logic [2:0]        flags_nx;
    logic              dec;
    logic              inc;
    logic              cond;
    logic              accept;
    logic [PEND_W-1:0] pend_eff;

    // Per-opcode flag write mask, {Z,V,N}
    always_comb begin
        wr_mask = 3'b000;
        case (alu_op)
            4'b0000, 4'b0001:                   wr_mask = 3'b111;
            4'b0010, 4'b0100, 4'b0101,
            4'b0110, 4'b0111:                   wr_mask = 3'b100;
            default:                            wr_mask = 3'b000;
        endcase
    end

    // Forwarded flag view and pending-count bookkeeping for this cycle
    always_comb begin
        dec      = ex_valid & (|wr_mask);
        inc      = id_fs_issue & ~br_valid;
        flags_nx = ex_valid ? ((flags_q & ~wr_mask) | (alu_flag & wr_mask)) : flags_q;
        pend_eff = (dec && (pend_q != PEND_ZERO)) ? (pend_q - PEND_W'(1)) : pend_q;
        br_ready = (pend_eff == PEND_ZERO);
    end

    // Branch condition on forwarded flags: Z=flags_nx[2], V=[1], N=[0]
    always_comb begin
        cond = 1'b0;
        case (br_ccc)
            3'b000:  cond = ~flags_nx[2];
            3'b001:  cond =  flags_nx[2];
            3'b010:  cond = ~flags_nx[2] & ~flags_nx[0];
            3'b011:  cond =  flags_nx[0];
            3'b100:  cond = ~flags_nx[0];
            3'b101:  cond =  flags_nx[0] | flags_nx[2];
            3'b110:  cond =  flags_nx[1];
            default: cond = 1'b1;
        endcase
    end

    // Next-state, pending counter, result latch and sticky error
    always_comb begin
        state_d    = state_q;
        flags_d    = flags_nx;
        pend_d     = pend_q;
        resolved_d = 1'b0;
        taken_d    = taken_q;
        npc_d      = npc_q;
        err_d      = err_q;
        accept     = br_valid & br_ready;

        if (inc && !dec) begin
            if (pend_q == PEND_MAX) err_d = 1'b1;
            else                    pend_d = pend_q + PEND_W'(1);
        end else if (dec && !inc) begin
            if (pend_q == PEND_ZERO) err_d = 1'b1;
            else                     pend_d = pend_q - PEND_W'(1);
        end

        if (id_fs_issue && br_valid) err_d = 1'b1;

        case (state_q)
            S_WAIT: begin
                if (!br_valid) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    accept  = 1'b0;
                end else if (br_ready) begin
                    state_d = S_RESOLVE;
                end
            end
            default: begin
                if (accept)        state_d = S_RESOLVE;
                else if (br_valid) state_d = S_WAIT;
                else               state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            resolved_d = 1'b1;
            taken_d    = cond;
            npc_d      = cond ? br_target : pc_next;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            flags_q    <= 3'b000;
            pend_q     <= PEND_ZERO;
            resolved_q <= 1'b0;
            taken_q    <= 1'b0;
            npc_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            flags_q    <= flags_d;
            pend_q     <= pend_d;
            resolved_q <= resolved_d;
            taken_q    <= taken_d;
            npc_q      <= npc_d;
            err_q      <= err_d;
        end
    end

    assign pend_cnt    = pend_q;
    assign br_resolved = resolved_q;
    assign br_taken    = taken_q;
    assign next_pc     = npc_q;
    assign err         = err_q;

endmodule

// File: doc/flag_branch_unit.md
# flag_branch_unit

Holds the processor's architectural Z/V/N flag register, written from the ALU's `Flag` output, and resolves conditional branches against it. Sits between ID and EX. It:
- tracks in-flight flag-setting instructions with a pending counter;
- stalls a branch in ID until every older flag writer has completed;
- forwards a same-cycle EX flag write into the branch decision;
- returns a registered taken/not-taken result and next PC one cycle after acceptance.

## Interface
Parameters:
- `PC_W`, 16, width of PC and branch target
- `PEND_W`, 2, width of pending flag-writer counter (max in flight = 2^PEND_W − 1)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `ex_valid`  in  1  EX stage holds a valid instruction this cycle
- `alu_op`  in  4  ALUOp of the EX instruction
- `alu_flag`  in  3  ALU `Flag` output, packed {Z,V,N}
- `id_fs_issue`  in  1  ID issues a flag-setting instruction into EX this cycle
- `br_valid`  in  1  ID holds a conditional branch; held stable until accepted
- `br_ccc`  in  3  branch condition code
- `br_target`  in  PC_W  taken target
- `pc_next`  in  PC_W  fall-through PC
- `br_ready`  out  1  branch accepted this cycle when high with `br_valid`
- `br_resolved`  out  1  one-cycle pulse, result valid
- `br_taken`  out  1  condition evaluated true
- `next_pc`  out  PC_W  `br_target` if taken, else `pc_next`
- `flags_q`  out  3  architectural {Z,V,N}
- `pend_cnt`  out  PEND_W  in-flight flag writers
- `err`  out  1  sticky protocol error

## Operation
- **Write mask by `alu_op`** (applied only when `ex_valid`=1):
  - 0000 ADD and 0001 SUB write Z, V and N.
  - 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR and 0111 PADDSB write Z only.
  - All other opcodes, including 1010/1011 LLB/LHB, write nothing.
- **Flag-setting instruction:** one whose opcode has a non-empty mask. `flags_nx` = `flags_q` with masked bits replaced by `alu_flag`.
- **Pending counter** (dec = `ex_valid` & flag-setting opcode):
  - `pend_cnt` += `id_fs_issue`, −= dec; increment and decrement in the same cycle leave it unchanged.
  - Increment at max: saturate and set `err`. Decrement at 0: hold 0 and set `err`.
- **`id_fs_issue` with `br_valid`:** illegal (ID holds one instruction). `id_fs_issue` is ignored and `err` is set.
- **`pend_eff`** = `pend_cnt` − dec. `br_ready` = (`pend_eff` == 0), combinational.
- **Condition** evaluated on `flags_nx`, i.e. forwarding an EX write in the same cycle:
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GE: !N
  - 101 LE: N | Z
  - 110 OV: V
  - 111 UN: 1
- **State machine:**
  - IDLE: `br_valid` & `br_ready` → RESOLVE, latching `br_taken` and `next_pc`. `br_valid` & !`br_ready` → WAIT.
  - WAIT: `br_ready` → RESOLVE with latch. `br_valid` dropped → IDLE and set `err`.
  - RESOLVE: `br_resolved`=1 for this cycle only. A new `br_valid` & `br_ready` latches the next branch and stays in RESOLVE (back-to-back). Otherwise WAIT or IDLE as from IDLE.
- **`err`:** cleared only by `rst`.

## Timing
- **Reset values:**
  - `flags_q`=000, `pend_cnt`=0, state IDLE.
  - `br_resolved`=0, `br_taken`=0, `next_pc`=0, `err`=0.
  - `br_ready`=1 while `pend_cnt`=0.
- **Reset mid-operation:** a held or resolving branch is dropped and nothing is emitted after reset deasserts.
- **Flag update:** `flags_q` updates at the edge ending the EX cycle, so new flags are visible on `flags_q` at T+1.
- **Branch latency:** accepted at cycle T → `br_resolved`, `br_taken` and `next_pc` are valid during T+1 only. Sustained throughput is 1 branch per cycle.
- **Stall length:** with k writers pending, `br_ready` rises in the cycle of the k-th completion (forwarded), never later.
- **Non-branch cycles:** `next_pc` and `br_taken` hold their last values when `br_resolved`=0.

## Test plan
- **Reset and masked update:** `rst` pulse → all outputs at reset values. ADD with `alu_flag`=111 → `flags_q`=111. Then XOR with `alu_flag`=000 → `flags_q`=011 (only Z cleared).
- **Condition sweep:** `flags_q`=100 (Z=1), no pending, `br_target`=0x0040, `pc_next`=0x0012:
  - ccc 001 → taken, `next_pc`=0x0040, one cycle after acceptance.
  - ccc 000 → not taken, `next_pc`=0x0012.
  - Sweep all 8 ccc against the equations above.
- **Forwarding:** `pend_cnt`=1 and SUB in EX with `alu_flag`=001 in the same cycle as `br_valid` with ccc=011 → `br_ready`=1, taken, and `flags_q`=001 at T+1.
- **Stall:** two `id_fs_issue` pulses, then `br_valid` → `br_ready`=0 for 2 cycles while ADD and SLL complete over 3 cycles. Ready rises in the SLL cycle, and `br_resolved` follows one cycle later.
- **Non-writers:** LLB (1010) in EX with `alu_flag`=100 → `flags_q` and `pend_cnt` unchanged.
- **Errors and reset:**
  - `br_valid` & `id_fs_issue` in one cycle → `err`=1 and `pend_cnt` unchanged.
  - `rst` asserted while in WAIT → state IDLE and no `br_resolved` pulse afterward.
